fb_arbiter: RTL and testbench

Shares the single framebuffer memory port between the display reader (feeds the video timing generator's pixel FIFO) and the pixel writer (drawing engine / CPU). Round-robin arbitration with bounded bursts, plus an optional urgency override so the display reader is served first when its FIFO runs low. The block sits between the two requesters and the memory controller in the `pixel_clk` domain. All accesses use a classic strobe/acknowledge handshake.

---
 rtl/fb_arbiter.sv | 137 +++++++++++++
 tb/tb_fb_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one framebuffer memory port between the display reader
// and the pixel writer. Round-robin arbitration with bursts bounded to
// MAX_BURST acknowledged accesses per grant. Strobe/acknowledge handshake
// on all sides; the memory port is a combinational mux on the grant state.
// Optional feature macro: FB_ARB_URGENT_EN (reader urgency override and
// writer preemption at access boundaries). Undefined: pure round-robin.
module fb_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16
) (
    input  logic              pixel_clk,
    input  logic              pixel_rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_adr,
    input  logic              rd_urgent,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_dat,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_adr,
    input  logic [DATA_W-1:0] wr_dat,
    output logic              wr_ack,
    output logic              mem_stb,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdat,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdat,
    output logic [1:0]        grant
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_RD = 2'd1,
        GNT_WR = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             last_wr_reg, last_wr_next;   // 1: writer was granted last
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             access;
    logic             urgent;

`ifdef FB_ARB_URGENT_EN
    assign urgent = rd_req & rd_urgent;
`else
    // Port kept for a uniform interface; it has no effect in this build.
    logic urgent_unused;
    assign urgent_unused = rd_urgent;
    assign urgent        = 1'b0;
`endif

    // State, round-robin pointer and burst counter registers.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state_reg   <= IDLE;
            last_wr_reg <= 1'b1;               // reader wins the first tie
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            last_wr_reg <= last_wr_next;
            cnt_reg     <= cnt_next;
        end
    end

    // Memory port and acknowledge routing, purely a function of the owner.
    always_comb begin
        mem_stb  = 1'b0;
        mem_we   = 1'b0;
        mem_adr  = '0;
        mem_wdat = '0;
        rd_ack   = 1'b0;
        wr_ack   = 1'b0;
        grant    = 2'b00;
        rd_dat   = mem_rdat;
        case (state_reg)
            GNT_RD: begin
                mem_stb = rd_req;
                mem_adr = rd_adr;
                rd_ack  = mem_ack;
                grant   = 2'b01;
            end
            GNT_WR: begin
                mem_stb  = wr_req;
                mem_we   = 1'b1;
                mem_adr  = wr_adr;
                mem_wdat = wr_dat;
                wr_ack   = mem_ack;
                grant    = 2'b10;
            end
            default: ;
        endcase
    end

    // Grant selection in IDLE and release decisions while a master owns the port.
    always_comb begin
        state_next   = state_reg;
        last_wr_next = last_wr_reg;
        cnt_next     = cnt_reg;
        access       = mem_stb & mem_ack;
        // Saturating increment keeps the counter from wrapping.
        cnt_inc      = (cnt_reg == MAX_CNT) ? cnt_reg : cnt_reg + 1'b1;
        case (state_reg)
            IDLE: begin
                if (urgent)
                    state_next = GNT_RD;
                else if (rd_req && wr_req)
                    state_next = last_wr_reg ? GNT_RD : GNT_WR;
                else if (rd_req)
                    state_next = GNT_RD;
                else if (wr_req)
                    state_next = GNT_WR;
                if (state_next != IDLE) begin
                    cnt_next     = '0;
                    last_wr_next = (state_next == GNT_WR);
                end
            end
            GNT_RD, GNT_WR: begin
                if (access)
                    cnt_next = cnt_inc;
                // A strobe that is high and unacknowledged never releases.
                if (!mem_stb)
                    state_next = IDLE;
                else if (access && (cnt_inc == MAX_CNT))
                    state_next = IDLE;
                else if ((state_reg == GNT_WR) && urgent && access)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Testbench for fb_arbiter: directed scenarios with literal expectations,
// then randomized requesters and memory, checked every cycle against a
// transaction-level model of the arbitration rules.
module tb_fb_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MAXB   = 4;
`ifdef FB_ARB_URGENT_EN
    localparam bit URG = 1'b1;
`else
    localparam bit URG = 1'b0;
`endif

    logic              pixel_clk = 1'b0;
    logic              pixel_rst;
    logic              rd_req, rd_urgent, rd_ack;
    logic [ADDR_W-1:0] rd_adr;
    logic [DATA_W-1:0] rd_dat;
    logic              wr_req, wr_ack;
    logic [ADDR_W-1:0] wr_adr;
    logic [DATA_W-1:0] wr_dat;
    logic              mem_stb, mem_we, mem_ack;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_wdat, mem_rdat;
    logic [1:0]        grant;

    int n_vec = 0;
    int n_err = 0;

    // Model: owner 0 = nobody, 1 = reader, 2 = writer; last = last owner.
    int m_owner, m_last, m_cnt;
    bit rd_done, wr_done;

    fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAXB)) dut (
        .pixel_clk(pixel_clk), .pixel_rst(pixel_rst),
        .rd_req(rd_req), .rd_adr(rd_adr), .rd_urgent(rd_urgent),
        .rd_ack(rd_ack), .rd_dat(rd_dat),
        .wr_req(wr_req), .wr_adr(wr_adr), .wr_dat(wr_dat), .wr_ack(wr_ack),
        .mem_stb(mem_stb), .mem_we(mem_we), .mem_adr(mem_adr),
        .mem_wdat(mem_wdat), .mem_ack(mem_ack), .mem_rdat(mem_rdat),
        .grant(grant)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_last  = 2;
        m_cnt   = 0;
        rd_done = 1'b0;
        wr_done = 1'b0;
    endtask

    // Let combinational outputs settle mid-cycle, then compare with the model.
    task automatic settle();
        logic [1:0]        e_grant;
        logic              e_stb;
        logic [ADDR_W-1:0] e_adr;
        logic [DATA_W-1:0] e_wdat;
        #3;
        e_grant = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
        e_stb   = (m_owner == 1) ? rd_req : (m_owner == 2) ? wr_req : 1'b0;
        e_adr   = (m_owner == 1) ? rd_adr : (m_owner == 2) ? wr_adr : '0;
        e_wdat  = (m_owner == 2) ? wr_dat : '0;
        check("grant",    64'(grant),    64'(e_grant));
        check("mem_stb",  64'(mem_stb),  64'(e_stb));
        check("mem_we",   64'(mem_we),   64'(m_owner == 2));
        check("mem_adr",  64'(mem_adr),  64'(e_adr));
        check("mem_wdat", 64'(mem_wdat), 64'(e_wdat));
        check("rd_ack",   64'(rd_ack),   64'(mem_ack && m_owner == 1));
        check("wr_ack",   64'(wr_ack),   64'(mem_ack && m_owner == 2));
        check("rd_dat",   64'(rd_dat),   64'(mem_rdat));
        rd_done = rd_req && mem_ack && (m_owner == 1);
        wr_done = wr_req && mem_ack && (m_owner == 2);
    endtask

    // Apply the arbitration rules to the current inputs, then cross the edge.
    task automatic advance();
        int  n_owner, n_last, n_cnt;
        bit  req, acked, urgent;
        n_owner = m_owner;
        n_last  = m_last;
        n_cnt   = m_cnt;
        urgent  = URG && rd_req && rd_urgent;
        if (m_owner == 0) begin
            if (urgent)                n_owner = 1;
            else if (rd_req && wr_req) n_owner = (m_last == 2) ? 1 : 2;
            else if (rd_req)           n_owner = 1;
            else if (wr_req)           n_owner = 2;
            if (n_owner != 0) begin
                n_last = n_owner;
                n_cnt  = 0;
            end
        end else begin
            req   = (m_owner == 1) ? rd_req : wr_req;
            acked = req && mem_ack;
            if (acked && n_cnt < MAXB) n_cnt = n_cnt + 1;
            if (!req || (acked && n_cnt == MAXB) || (m_owner == 2 && urgent && acked))
                n_owner = 0;
        end
        @(posedge pixel_clk);
        #1;
        m_owner = n_owner;
        m_last  = n_last;
        m_cnt   = n_cnt;
    endtask

    // Reset asserted mid-cycle: outputs must drop without waiting for an edge.
    task automatic reset_now();
        #2;
        pixel_rst = 1'b1;
        #1;
        check("rst_mem_stb", 64'(mem_stb), 64'd0);
        check("rst_grant",   64'(grant),   64'd0);
        check("rst_rd_ack",  64'(rd_ack),  64'd0);
        check("rst_wr_ack",  64'(wr_ack),  64'd0);
        rd_req = 1'b0;
        wr_req = 1'b0;
        @(posedge pixel_clk);
        #1;
        pixel_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int wr_pulses, first_rd, wr_before;
        logic [1:0] exp_g;
        pixel_rst = 1'b1;
        rd_req = 0; rd_adr = 0; rd_urgent = 0;
        wr_req = 0; wr_adr = 0; wr_dat = 0;
        mem_ack = 1'b1; mem_rdat = 32'hCAFE_0001;
        model_reset();
        @(posedge pixel_clk);
        #1;
        check("reset_grant",    64'(grant),    64'd0);
        check("reset_mem_stb",  64'(mem_stb),  64'd0);
        check("reset_mem_adr",  64'(mem_adr),  64'd0);
        check("reset_mem_wdat", 64'(mem_wdat), 64'd0);
        check("reset_acks",     64'({rd_ack, wr_ack}), 64'd0);
        check("reset_rd_dat",   64'(rd_dat),   64'hCAFE_0001);
        @(posedge pixel_clk);
        #1;
        pixel_rst = 1'b0;
        mem_ack = 1'b0;

        // Single writer, three writes acked one cycle after the strobe.
        wr_req = 1; wr_adr = 32'h100; wr_dat = 32'hA0;
        settle();
        check("wr_idle_grant", 64'(grant), 64'd0);
        advance();
        wr_pulses = 0;
        for (int k = 0; k < 3; k++) begin
            mem_ack = 0;
            settle();
            check("wr_grant", 64'(grant), 64'h2);
            check("wr_we",    64'(mem_we), 64'd1);
            check("wr_adr",   64'(mem_adr), 64'(32'h100 + k));
            wr_pulses += int'(wr_ack);
            advance();
            mem_ack = 1;
            settle();
            wr_pulses += int'(wr_ack);
            advance();
            wr_adr = 32'h101 + k; wr_dat = 32'hA1 + k;
        end
        check("wr_pulses", 64'(wr_pulses), 64'd3);
        wr_req = 0; mem_ack = 0;
        settle();
        advance();
        settle();
        check("wr_released", 64'(grant), 64'd0);
        advance();

        // Stray acknowledges while nobody owns the port.
        mem_ack = 1;
        for (int k = 0; k < 2; k++) begin
            settle();
            check("stray_acks", 64'({rd_ack, wr_ack}), 64'd0);
            advance();
        end

        // Both masters requesting with every access acked: grants alternate
        // in groups of MAXB with one idle cycle, reader first (writer was last).
        rd_req = 1; wr_req = 1;
        for (int k = 0; k < 16; k++) begin
            rd_adr = 32'h2000 + k; wr_adr = 32'h3000 + k; wr_dat = k;
            settle();
            if (k % (MAXB + 1) == 0) exp_g = 2'b00;
            else exp_g = ((k / (MAXB + 1)) % 2 == 0) ? 2'b01 : 2'b10;
            check("alt_grant", 64'(grant), 64'(exp_g));
            advance();
        end
        rd_req = 0; wr_req = 0;
        for (int k = 0; k < 2; k++) begin settle(); advance(); end

        // Stall: the owner's strobe stays up for 10+ cycles with no acknowledge.
        mem_ack = 0; wr_req = 1; wr_adr = 32'h4444; wr_dat = 32'h55;
        settle();
        advance();
        for (int k = 0; k < 11; k++) begin
            settle();
            check("stall_grant", 64'(grant),   64'h2);
            check("stall_stb",   64'(mem_stb), 64'd1);
            check("stall_adr",   64'(mem_adr), 64'h4444);
            advance();
        end
        // Reset arrives while that access is still unacknowledged.
        reset_now();
        settle();
        check("post_reset_grant", 64'(grant), 64'd0);
        advance();

        // Urgency during a writer burst.
        mem_ack = 1; wr_req = 1; rd_adr = 32'h77;
        first_rd = -1; wr_before = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 2) begin rd_req = 1; rd_urgent = 1; end
            wr_adr = 32'h5000 + k; wr_dat = 32'h900 + k;
            settle();
            if (first_rd < 0 && grant == 2'b01) first_rd = k;
            if (first_rd < 0 && wr_ack) wr_before++;
            advance();
        end
        check("urgent_first_rd", 64'(first_rd),  URG ? 64'd4 : 64'd6);
        check("urgent_wr_acks",  64'(wr_before), URG ? 64'd2 : 64'd4);
        rd_req = 0; wr_req = 0; rd_urgent = 0;
        for (int k = 0; k < 2; k++) begin settle(); advance(); end

        // Randomized traffic; requesters hold their request until acknowledged.
        rd_done = 0; wr_done = 0;
        for (int k = 0; k < 3000; k++) begin
            if (!(rd_req && !rd_done)) begin
                rd_req = ($urandom_range(0, 3) != 0);
                rd_adr = $urandom;
            end
            if (!(wr_req && !wr_done)) begin
                wr_req = ($urandom_range(0, 3) != 0);
                wr_adr = $urandom;
                wr_dat = $urandom;
            end
            rd_urgent = ($urandom_range(0, 3) == 0);
            mem_ack   = ($urandom_range(0, 1) == 1);
            mem_rdat  = $urandom;
            settle();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
